if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Parametrised instruction buffer between the fetch (IF) and decode (ID) stages.
//  Generalises the single-entry IF/ID pipeline latch into a DEPTH-entry FIFO of {pc, inst} pairs.
//  Uses valid/ready handshakes on both sides, a single-cycle flush for redirects, and a global rdy freeze.
//  When no entry is available, it presents a zero bubble to ID.
// PARAMETERS
//  ADDR_W  32  width of the pc field (InstAddrBus)
//  INST_W  32  width of the instruction field (InstBus)
//  DEPTH   4   number of entries; must be a power of 2, >= 2
//  PTR_W   2   log2(DEPTH); read/write pointer width
// PORTS
//  clk        in   1         clock; all state changes on posedge
//  rst        in   1         synchronous, active-high reset
//  rdy        in   1         global enable; when 0 all state holds
//  flush      in   1         discard all entries (branch/jump redirect)
//  in_valid   in   1         IF presents {in_pc, in_inst}
//  in_ready   out  1         queue accepts a push this cycle
//  in_pc      in   ADDR_W    fetched pc
//  in_inst    in   INST_W    fetched instruction
//  out_valid  out  1         head entry available to ID
//  out_ready  in   1         ID consumes head this cycle (low = ID stall)
//  out_pc     out  ADDR_W    head pc; 0 when out_valid=0
//  out_inst   out  INST_W    head inst; 0 when out_valid=0 (bubble)
//  count      out  PTR_W+1   current occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=0, rd_ptr=0, count=0.
//    Resulting outputs: in_ready=1, out_valid=0, out_pc=0, out_inst=0.
//    Storage array contents are not reset. Reset overrides rdy and flush.
//  - Outputs are combinational from state:
//    in_ready = (count != DEPTH); out_valid = (count != 0);
//    out_pc/out_inst = mem[rd_ptr] when out_valid, else 0.
//  - push = rdy & in_valid & in_ready & ~flush. On push: mem[wr_ptr] <= {in_pc, in_inst}; wr_ptr += 1.
//  - pop = rdy & out_valid & out_ready & ~flush. On pop: rd_ptr += 1.
//  - count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
//  - Latency: an entry pushed at edge N is visible on out_* after edge N (1 cycle). There is no IF->ID bypass when empty.
//  - Full: in_ready=0 even if out_ready=1 the same cycle. No push-through on full.
//  - Empty: out_ready is ignored; no pop occurs.
//  - Pointers wrap modulo DEPTH (natural PTR_W overflow). count never exceeds DEPTH or goes below 0.
//  - Flush (rdy=1): at the next edge wr_ptr=rd_ptr=0 and count=0.
//    Any same-cycle push and pop are discarded.
//    out_valid=0 from the cycle after flush.
//  - rdy=0: pointers, count and storage hold regardless of in_valid, out_ready and flush.
//    Outputs still reflect the held state.
//  - Reset mid-operation: all in-flight entries are lost. Identical to flush except it also ignores rdy.
//  - Protocol: an upstream holding in_valid with in_ready=0 keeps in_pc/in_inst stable.
//    The queue itself places no requirement on that.
// TESTING (DEPTH=4)
//  1. rst for 2 cycles -> count=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1.
//  2. Push pc 0x00/0x04/0x08/0x0C with out_ready=0 ->
//     count=4, in_ready=0; 5th push (pc 0x10) is not accepted; out_pc=0x00.
//  3. From full, out_ready=1 and in_valid=1 for one cycle ->
//     pop only, count=3, out_pc=0x04; the next cycle accepts 0x10.
//  4. Stream 10 pushes with out_ready=1 each cycle ->
//     out_pc sequence 0x00..0x24 in order, each one cycle after its push.
//     count stays at 1 and pointers wrap correctly.
//  5. count=3, assert flush together with in_valid and out_ready ->
//     next cycle count=0, out_valid=0, out_inst=0. A following push of pc 0x40 appears at the head.
//  6. count=2, rdy=0 for 3 cycles with in_valid=1, out_ready=1, flush=1 ->
//     count=2 and head unchanged; normal operation resumes when rdy=1.

Source files
------------

// File: rtl/if_id_queue_if.sv
// Handshake bundle between the IF/ID instruction queue and its neighbours.
// slave is the queue's view; master is the view of the stages driving it.
interface if_id_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned PTR_W  = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;
  logic [PTR_W:0]    count;

  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {pc, inst} pairs between fetch and decode, with redirect
// flush, a global rdy freeze and a zero bubble presented to ID when empty.
module if_id_queue #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  if_id_queue_if.slave       q
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = rdy & q.in_valid & in_ready & ~flush;
  assign pop       = rdy & out_valid & q.out_ready & ~flush;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy && flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after a
  // push wrote it, and out_* are forced to zero while the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: q.in_pc, inst: q.in_inst};
  end

  assign q.in_ready  = in_ready;
  assign q.out_valid = out_valid;
  assign q.out_pc    = out_valid ? mem_q[rd_ptr_q].pc   : '0;
  assign q.out_inst  = out_valid ? mem_q[rd_ptr_q].inst : '0;
  assign q.count     = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4): fill/full, pop from full, streaming
// with pointer wrap, flush, rdy freeze and mid-operation reset.
module tb_if_id_queue;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = 2;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic flush;

  int checks = 0;
  int errors = 0;

  if_id_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .PTR_W(PTR_W)) q_if ();

  if_id_queue #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .PTR_W(PTR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .q     (q_if)
  );

  always #5 clk = ~clk;

  // Instruction word paired with each pc, so the inst field is checked too.
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA5A5_0000 ^ pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic ordy);
    q_if.in_valid  = v;
    q_if.in_pc     = pc;
    q_if.in_inst   = inst_of(pc);
    q_if.out_ready = ordy;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_pc"},   q_if.out_pc,   pc);
    check({tag, "_inst"}, q_if.out_inst, inst_of(pc));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // 1. reset state
    check("rst_count",     32'(q_if.count), 32'd0);
    check("rst_out_valid", 32'(q_if.out_valid), 32'd0);
    check("rst_out_pc",    q_if.out_pc, 32'd0);
    check("rst_out_inst",  q_if.out_inst, 32'd0);
    check("rst_in_ready",  32'(q_if.in_ready), 32'd1);

    // 2. fill to full with ID stalled; 5th push refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0);
      tick();
      check("fill_count", 32'(q_if.count), 32'(i + 1));
    end
    check("full_in_ready", 32'(q_if.in_ready), 32'd0);
    check_head("full_head", 32'h00);
    drive(1'b1, 32'h10, 1'b0);
    tick();
    check("full_hold_count", 32'(q_if.count), 32'd4);
    check_head("full_hold_head", 32'h00);

    // 3. from full: pop only, then 0x10 accepted next cycle
    drive(1'b1, 32'h10, 1'b1);
    tick();
    check("popfull_count", 32'(q_if.count), 32'd3);
    check_head("popfull_head", 32'h04);
    check("popfull_in_ready", 32'(q_if.in_ready), 32'd1);
    drive(1'b1, 32'h10, 1'b0);
    tick();
    check("refill_count", 32'(q_if.count), 32'd4);
    check_head("refill_head", 32'h04);

    // drain: 0x04 leaves, then 0x08, 0x0C, 0x10; empty presents a bubble
    drive(1'b0, 32'h0, 1'b1);
    tick(); check_head("drain1", 32'h08);
    tick(); check_head("drain2", 32'h0C);
    tick(); check_head("drain3", 32'h10);
    tick();
    check("drain_count", 32'(q_if.count), 32'd0);
    check("drain_out_valid", 32'(q_if.out_valid), 32'd0);
    check("drain_bubble_pc", q_if.out_pc, 32'd0);
    check("drain_bubble_inst", q_if.out_inst, 32'd0);
    tick();
    check("empty_ready_ignored", 32'(q_if.count), 32'd0);

    // 4. streaming 10 pushes with ID always ready; pointers wrap twice
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(4 * i), 1'b1);
      tick();
      check("stream_count", 32'(q_if.count), 32'd1);
      check_head("stream_head", 32'(4 * i));
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("stream_end_count", 32'(q_if.count), 32'd0);

    // 5. flush at count=3 with simultaneous push and pop
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h30 + 32'(4 * i), 1'b0);
      tick();
    end
    check("preflush_count", 32'(q_if.count), 32'd3);
    drive(1'b1, 32'h3C, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 32'(q_if.count), 32'd0);
    check("flush_out_valid", 32'(q_if.out_valid), 32'd0);
    check("flush_out_inst", q_if.out_inst, 32'd0);
    drive(1'b1, 32'h40, 1'b0);
    tick();
    check("postflush_count", 32'(q_if.count), 32'd1);
    check_head("postflush_head", 32'h40);

    // 6. rdy=0 freeze at count=2 with every other control active
    drive(1'b1, 32'h44, 1'b0);
    tick();
    check("prefreeze_count", 32'(q_if.count), 32'd2);
    rdy = 1'b0; flush = 1'b1;
    drive(1'b1, 32'h48, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_count", 32'(q_if.count), 32'd2);
      check_head("freeze_head", 32'h40);
    end
    rdy = 1'b1; flush = 1'b0;
    drive(1'b0, 32'h0, 1'b1);
    tick();
    check("resume_count", 32'(q_if.count), 32'd1);
    check_head("resume_head", 32'h44);

    // reset mid-operation overrides rdy=0
    drive(1'b1, 32'h50, 1'b0);
    tick();
    check("premrst_count", 32'(q_if.count), 32'd2);
    rdy = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; rdy = 1'b1;
    check("midrst_count", 32'(q_if.count), 32'd0);
    check("midrst_out_valid", 32'(q_if.out_valid), 32'd0);
    check("midrst_in_ready", 32'(q_if.in_ready), 32'd1);

    drive(1'b0, 32'h0, 1'b0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
